// File: rtl/operand_fetch.sv
// Register-read stage between decode and execute: fetches up to three source
// operands one per cycle through a single register-file read port.
module operand_fetch (
   input  logic        clk,
   input  logic        reset,
   // decode side
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic [3:0]  in_rn,
   input  logic [3:0]  in_rm,
   input  logic [3:0]  in_rs,
   input  logic        in_use_rn,
   input  logic        in_use_rm,
   input  logic        in_use_rs,
   // register file read port
   output logic [3:0]  rf_read_addr,
   input  logic [31:0] rf_read_data,
   // writeback bypass
   input  logic        wb_valid,
   input  logic [3:0]  wb_addr,
   input  logic [31:0] wb_data,
   // execute side
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_op_n,
   output logic [31:0] out_op_m,
   output logic [31:0] out_op_s
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_N,
      ST_RD_M,
      ST_RD_S,
      ST_DONE
   } state_t;

   localparam logic [3:0] PC_REG = 4'd15;

   state_t      r_state;
   state_t      w_next_state;

   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic [3:0]  r_rn;
   logic [3:0]  r_rm;
   logic [3:0]  r_rs;
   logic        r_use_m;
   logic        r_use_s;
   logic [31:0] r_op_n;
   logic [31:0] r_op_m;
   logic [31:0] r_op_s;

   logic        w_accept;
   logic        w_fwd_hit;
   logic [31:0] w_pc_plus8;
   logic [31:0] w_sel_val;

   // Earliest read state among the operands still to be fetched.
   function automatic state_t first_used(input logic use_n,
                                         input logic use_m,
                                         input logic use_s);
      state_t st;
      if (use_n)
         st = ST_RD_N;
      else if (use_m)
         st = ST_RD_M;
      else if (use_s)
         st = ST_RD_S;
      else
         st = ST_DONE;
      return st;
   endfunction

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign w_accept  = in_ready & in_valid;

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   // NOTE: every combinational output gets a default before the case so that
   // no path leaves it unassigned and a latch is inferred.
   always_comb begin
      w_next_state = r_state;
      rf_read_addr = 4'd0;
      case (r_state)
         ST_IDLE: begin
            if (in_valid)
               w_next_state = first_used(in_use_rn, in_use_rm, in_use_rs);
         end
         ST_RD_N: begin
            rf_read_addr = r_rn;
            w_next_state = first_used(1'b0, r_use_m, r_use_s);
         end
         ST_RD_M: begin
            rf_read_addr = r_rm;
            w_next_state = first_used(1'b0, 1'b0, r_use_s);
         end
         ST_RD_S: begin
            rf_read_addr = r_rs;
            w_next_state = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready)
               w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // r15 reads return PC+8 even when a writeback targets r15 this cycle.
   assign w_pc_plus8 = r_pc + 32'd8;
   assign w_fwd_hit  = wb_valid && (wb_addr == rf_read_addr);

   always_comb begin
      if (rf_read_addr == PC_REG)
         w_sel_val = w_pc_plus8;
      else if (w_fwd_hit)
         w_sel_val = wb_data;
      else
         w_sel_val = rf_read_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instr <= 32'd0;
         r_pc    <= 32'd0;
         r_rn    <= 4'd0;
         r_rm    <= 4'd0;
         r_rs    <= 4'd0;
         r_use_m <= 1'b0;
         r_use_s <= 1'b0;
         r_op_n  <= 32'd0;
         r_op_m  <= 32'd0;
         r_op_s  <= 32'd0;
      end else if (w_accept) begin
         r_instr <= in_instr;
         r_pc    <= in_pc;
         r_rn    <= in_rn;
         r_rm    <= in_rm;
         r_rs    <= in_rs;
         r_use_m <= in_use_rm;
         r_use_s <= in_use_rs;
         r_op_n  <= 32'd0;
         r_op_m  <= 32'd0;
         r_op_s  <= 32'd0;
      end else begin
         case (r_state)
            ST_RD_N: r_op_n <= w_sel_val;
            ST_RD_M: r_op_m <= w_sel_val;
            ST_RD_S: r_op_s <= w_sel_val;
            default: ;
         endcase
      end
   end

   assign out_instr = r_instr;
   assign out_pc    = r_pc;
   assign out_op_n  = r_op_n;
   assign out_op_m  = r_op_m;
   assign out_op_s  = r_op_s;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: queue-based transaction model checked every cycle,
// plus directed vectors with hand-computed operand values and latencies.
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [3:0]  in_rn, in_rm, in_rs;
   logic        in_use_rn, in_use_rm, in_use_rs;
   logic [3:0]  rf_read_addr;
   logic [31:0] rf_read_data;
   logic        wb_valid;
   logic [3:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr, out_pc;
   logic [31:0] out_op_n, out_op_m, out_op_s;

   logic [31:0] rf [16];
   assign rf_read_data = rf[rf_read_addr];

   operand_fetch dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .in_rn        (in_rn),
      .in_rm        (in_rm),
      .in_rs        (in_rs),
      .in_use_rn    (in_use_rn),
      .in_use_rm    (in_use_rm),
      .in_use_rs    (in_use_rs),
      .rf_read_addr (rf_read_addr),
      .rf_read_data (rf_read_data),
      .wb_valid     (wb_valid),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .out_op_n     (out_op_n),
      .out_op_m     (out_op_m),
      .out_op_s     (out_op_s)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // ---------------- transaction model ----------------
   typedef struct {
      int         slot;
      logic [3:0] idx;
   } rd_t;

   rd_t         pend[$];
   bit          busy;
   logic [31:0] m_instr, m_pc;
   logic [31:0] m_op [3];

   task automatic model_reset();
      busy = 1'b0;
      pend.delete();
      m_instr = 32'd0;
      m_pc    = 32'd0;
      for (int i = 0; i < 3; i++) m_op[i] = 32'd0;
   endtask

   // Advance the model across the upcoming rising edge using current inputs.
   task automatic model_step();
      rd_t         r;
      logic [31:0] v;
      if (!busy) begin
         if (in_valid) begin
            busy    = 1'b1;
            m_instr = in_instr;
            m_pc    = in_pc;
            for (int i = 0; i < 3; i++) m_op[i] = 32'd0;
            if (in_use_rn) pend.push_back('{0, in_rn});
            if (in_use_rm) pend.push_back('{1, in_rm});
            if (in_use_rs) pend.push_back('{2, in_rs});
         end
      end else if (pend.size() != 0) begin
         r = pend.pop_front();
         if (r.idx == 4'd15)
            v = m_pc + 32'd8;
         else if (wb_valid && wb_addr == r.idx)
            v = wb_data;
         else
            v = rf[r.idx];
         m_op[r.slot] = v;
      end else if (out_ready) begin
         busy = 1'b0;
      end
   endtask

   always begin
      @(negedge clk);
      if (reset) model_reset();
      check("m_in_ready",  32'(in_ready),  32'(!busy));
      check("m_out_valid", 32'(out_valid), 32'(busy && pend.size() == 0));
      check("m_rf_addr",   32'(rf_read_addr), (pend.size() != 0) ? 32'(pend[0].idx) : 32'd0);
      check("m_out_instr", out_instr, m_instr);
      check("m_out_pc",    out_pc,    m_pc);
      check("m_op_n",      out_op_n,  m_op[0]);
      check("m_op_m",      out_op_m,  m_op[1]);
      check("m_op_s",      out_op_s,  m_op[2]);
      if (!reset) model_step();
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rs,
                        input logic un, input logic um, input logic us);
      check("offer_in_ready", 32'(in_ready), 32'd1);
      in_instr  = instr;
      in_pc     = pc;
      in_rn     = rn;
      in_rm     = rm;
      in_rs     = rs;
      in_use_rn = un;
      in_use_rm = um;
      in_use_rs = us;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      // Scramble fields: they must be ignored after the accept cycle.
      in_instr  = ~instr;
      in_pc     = pc ^ 32'h5A5A_A5A5;
      in_rn     = rn + 4'd1;
      in_rm     = rm + 4'd1;
      in_rs     = rs + 4'd1;
      in_use_rn = ~un;
      in_use_rm = ~um;
      in_use_rs = ~us;
   endtask

   task automatic wait_valid(input int k, input string name);
      int n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check(name, 32'(n), 32'(k));
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hs_in_ready", 32'(in_ready), 32'd1);
      check("hs_out_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   // ---------------- directed vectors ----------------
   initial begin
      for (int i = 0; i < 16; i++) rf[i] = 32'hDEAD_0000 | 32'(i);
      rf[1] = 32'h11;
      rf[2] = 32'h22;
      rf[3] = 32'h33;
      rf[4] = 32'hAAAA;
      rf[5] = 32'h5050;
      reset = 1'b1;
      in_valid = 1'b0; in_instr = '0; in_pc = '0;
      in_rn = '0; in_rm = '0; in_rs = '0;
      in_use_rn = 1'b0; in_use_rm = 1'b0; in_use_rs = 1'b0;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      out_ready = 1'b0;
      #1;
      check("rst_in_ready",  32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_rf_addr",   32'(rf_read_addr), 32'd0);
      check("rst_op_n",      out_op_n, 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // Three operands: addresses 1,2,3 on successive cycles, valid at T+4.
      offer(32'hE081_0002, 32'h1000, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1);
      check("three_addr1", 32'(rf_read_addr), 32'd1); tick();
      check("three_addr2", 32'(rf_read_addr), 32'd2); tick();
      check("three_addr3", 32'(rf_read_addr), 32'd3);
      check("three_nv3",   32'(out_valid), 32'd0);    tick();
      check("three_valid", 32'(out_valid), 32'd1);
      check("three_op_n",  out_op_n, 32'h11);
      check("three_op_m",  out_op_m, 32'h22);
      check("three_op_s",  out_op_s, 32'h33);
      check("three_instr", out_instr, 32'hE081_0002);
      handshake();

      // r15 reads PC+8; unused operands are zero.
      offer(32'h1, 32'h100, 4'd15, 4'd7, 4'd9, 1'b1, 1'b0, 1'b0);
      wait_valid(1, "pc_latency");
      check("pc_op_n", out_op_n, 32'h108);
      check("pc_op_m", out_op_m, 32'h0);
      check("pc_op_s", out_op_s, 32'h0);
      handshake();

      offer(32'h2, 32'hFFFF_FFFC, 4'd15, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      wait_valid(1, "wrap_latency");
      check("wrap_op_n", out_op_n, 32'h4);
      handshake();

      // Writeback forwarding during RD_N.
      offer(32'h3, 32'h300, 4'd4, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      wb_valid = 1'b1; wb_addr = 4'd4; wb_data = 32'h5555;
      tick();
      wb_valid = 1'b0;
      check("fwd_valid", 32'(out_valid), 32'd1);
      check("fwd_op_n",  out_op_n, 32'h5555);
      handshake();

      // Writeback to r15 never overrides PC+8.
      offer(32'h4, 32'h200, 4'd15, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      wb_valid = 1'b1; wb_addr = 4'd15; wb_data = 32'h5555;
      tick();
      wb_valid = 1'b0;
      check("r15wb_op_n", out_op_n, 32'h208);
      handshake();

      // Same register three times, writeback only during the second read.
      offer(32'h5, 32'h500, 4'd5, 4'd5, 4'd5, 1'b1, 1'b1, 1'b1);
      tick();
      wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 32'h7777;
      tick();
      wb_valid = 1'b0;
      tick();
      check("same_valid", 32'(out_valid), 32'd1);
      check("same_op_n",  out_op_n, 32'h5050);
      check("same_op_m",  out_op_m, 32'h7777);
      check("same_op_s",  out_op_s, 32'h5050);
      handshake();

      // Backpressure: hold DONE for 5 cycles with stray in_valid pulses.
      offer(32'h6, 32'h600, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b1);
      wait_valid(2, "bp_latency");
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         in_instr = 32'hBAD0_0000 | 32'(i);
         tick();
         check("bp_valid",    32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_op_n",     out_op_n, 32'h11);
         check("bp_op_m",     out_op_m, 32'h0);
         check("bp_op_s",     out_op_s, 32'h33);
         check("bp_instr",    out_instr, 32'h6);
      end
      in_valid = 1'b1;
      handshake();
      in_valid = 1'b0;
      tick();
      check("bp_no_accept", 32'(in_ready), 32'd1);

      // Zero operands: valid the cycle after accept.
      offer(32'hCAFE_BABE, 32'h4444, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0);
      wait_valid(0, "zero_latency");
      check("zero_op_n",  out_op_n, 32'h0);
      check("zero_op_m",  out_op_m, 32'h0);
      check("zero_op_s",  out_op_s, 32'h0);
      check("zero_instr", out_instr, 32'hCAFE_BABE);
      check("zero_pc",    out_pc, 32'h4444);
      handshake();

      // Reset during RD_M abandons the instruction immediately.
      offer(32'h7, 32'h700, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1);
      tick();
      check("mid_addr", 32'(rf_read_addr), 32'd2);
      reset = 1'b1;
      #1;
      check("mid_in_ready",  32'(in_ready), 32'd1);
      check("mid_out_valid", 32'(out_valid), 32'd0);
      check("mid_rf_addr",   32'(rf_read_addr), 32'd0);
      check("mid_op_n",      out_op_n, 32'd0);
      check("mid_instr",     out_instr, 32'd0);
      check("mid_pc",        out_pc, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      offer(32'h8, 32'h800, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      wait_valid(1, "post_rst_latency");
      check("post_rst_op_n", out_op_n, 32'h22);
      check("post_rst_op_m", out_op_m, 32'h0);
      handshake();

      tick(); tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
